// File: rtl/axis_len_framer.sv
// axis_len_framer: length-driven AXI4-Stream TX framer.
// Takes a per-frame byte count, pulls ceil(len/8) 64-bit words from the upstream
// source and presents them through a one-entry registered output stage.
// The final beat carries m_tlast and a keep mask derived from the residual bytes.
module axis_len_framer #(
   parameter int C_LEN_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [C_LEN_WIDTH-1:0] cmd_len,
   input  logic                   din_valid,
   output logic                   din_ready,
   input  logic [63:0]            din_data,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [63:0]            m_tdata,
   output logic [7:0]             m_tkeep,
   output logic                   m_tlast,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   err_zero_len
);

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [C_LEN_WIDTH-1:0] rem_q, rem_d;
   logic                   m_tvalid_q, m_tvalid_d;
   logic [63:0]            m_tdata_q, m_tdata_d;
   logic [7:0]             m_tkeep_q, m_tkeep_d;
   logic                   m_tlast_q, m_tlast_d;
   logic                   frame_done_q, frame_done_d;
   logic                   err_zero_len_q, err_zero_len_d;

   logic                   cmd_fire;
   logic                   pull;
   logic                   rem_gt8;
   logic [7:0]             keep_last;

   assign cmd_fire = cmd_valid && cmd_ready;
   assign pull     = din_valid && din_ready;
   assign rem_gt8  = (rem_q > C_LEN_WIDTH'(8));

   // Residual keep for the last beat: with 1..8 bytes left, lane gi is enabled
   // when more than gi bytes remain (LSB-first).
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_keep
         assign keep_last[gi] = (rem_q[3:0] > 4'(gi));
      end
   endgenerate

   // State register and output stage, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         rem_q          <= '0;
         m_tvalid_q     <= 1'b0;
         m_tdata_q      <= '0;
         m_tkeep_q      <= '0;
         m_tlast_q      <= 1'b0;
         frame_done_q   <= 1'b0;
         err_zero_len_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         rem_q          <= rem_d;
         m_tvalid_q     <= m_tvalid_d;
         m_tdata_q      <= m_tdata_d;
         m_tkeep_q      <= m_tkeep_d;
         m_tlast_q      <= m_tlast_d;
         frame_done_q   <= frame_done_d;
         err_zero_len_q <= err_zero_len_d;
      end
   end

   // Next-state: command acceptance, word pull into the output stage, drain
   always_comb begin
      state_d        = state_q;
      rem_d          = rem_q;
      m_tvalid_d     = m_tvalid_q;
      m_tdata_d      = m_tdata_q;
      m_tkeep_d      = m_tkeep_q;
      m_tlast_d      = m_tlast_q;
      frame_done_d   = m_tvalid_q && m_tready && m_tlast_q;
      err_zero_len_d = cmd_fire && (cmd_len == '0);

      case (state_q)
         IDLE: begin
            if (cmd_fire && (cmd_len != '0)) begin
               rem_d   = cmd_len;
               state_d = XFER;
            end
         end
         XFER: begin
            if (pull && !rem_gt8) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A pull refills the stage even while it drains; otherwise a taken beat empties it
      if (pull) begin
         m_tvalid_d = 1'b1;
         m_tdata_d  = din_data;
         if (rem_gt8) begin
            m_tkeep_d = 8'hFF;
            m_tlast_d = 1'b0;
            rem_d     = rem_q - C_LEN_WIDTH'(8);
         end else begin
            m_tkeep_d = keep_last;
            m_tlast_d = 1'b1;
            rem_d     = '0;
         end
      end else if (m_tvalid_q && m_tready) begin
         m_tvalid_d = 1'b0;
      end
   end

   // Outputs: handshake readiness derived from state and output-stage occupancy
   always_comb begin
      cmd_ready    = (state_q == IDLE);
      din_ready    = (state_q == XFER) && (!m_tvalid_q || m_tready);
      busy         = (state_q == XFER) || m_tvalid_q;
      m_tvalid     = m_tvalid_q;
      m_tdata      = m_tdata_q;
      m_tkeep      = m_tkeep_q;
      m_tlast      = m_tlast_q;
      frame_done   = frame_done_q;
      err_zero_len = err_zero_len_q;
   end

endmodule

// File: doc/axis_len_framer.md
# axis_len_framer

Length-driven AXI4-Stream TX framer for the 10GE datapath. It accepts a per-frame byte-length command, pulls the corresponding number of 64-bit words from an upstream data source, and emits them on a registered AXI-Stream master. It generates `m_tlast` on the final beat and derives `m_tkeep` for that beat from the residual byte count (1..8, LSB-first, the same mapping as the count-to-keep decoder). All other beats carry `m_tkeep = 8'hFF`.

## Interface
- `C_LEN_WIDTH`, default 16: width of the frame byte-length command. Maximum frame is 2^C_LEN_WIDTH-1 bytes.
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: frame command valid.
- `cmd_ready` out 1: framer can accept a command.
- `cmd_len` in C_LEN_WIDTH: frame length in bytes.
- `din_valid` in 1: upstream data word valid.
- `din_ready` out 1: framer accepts the upstream word this cycle.
- `din_data` in 64: upstream data word; byte 0 is in [7:0].
- `m_tvalid` out 1: output beat valid.
- `m_tready` in 1: downstream ready.
- `m_tdata` out 64: output data.
- `m_tkeep` out 8: output byte enables.
- `m_tlast` out 1: last beat of the frame.
- `busy` out 1: a frame is in progress or an output beat is pending.
- `frame_done` out 1: one-cycle pulse when the last beat handshakes on the master side.
- `err_zero_len` out 1: one-cycle pulse when a zero-length command is accepted.

## Operation
- States: IDLE, XFER. Registers: `rem` (C_LEN_WIDTH, bytes still to pull) and a one-entry output stage {`m_tvalid`, `m_tdata`, `m_tkeep`, `m_tlast`}.
- IDLE: `cmd_ready = 1`.
  - Command handshake with `cmd_len != 0`: `rem <= cmd_len`, go to XFER.
  - Command handshake with `cmd_len == 0`: pulse `err_zero_len`, stay in IDLE, emit no beat.
- XFER: `cmd_ready = 0`.
  - `din_ready = !m_tvalid || m_tready`, so an upstream word is pulled only when the output stage is empty or draining this cycle.
- Upstream pull (`din_valid && din_ready`):
  - Load the output stage with `din_data` and set `m_tvalid <= 1`.
  - If `rem > 8`: `m_tkeep <= 8'hFF`, `m_tlast <= 0`, `rem <= rem - 8`.
  - If `rem <= 8`: `m_tkeep <=` keep(`rem`) (1→8'h01, 2→8'h03 … 8→8'hFF), `m_tlast <= 1`, `rem <= 0`, go to IDLE.
- Output stage drain: on `m_tvalid && m_tready` with no simultaneous pull, `m_tvalid <= 0`.
  - While `m_tvalid && !m_tready`, `m_tdata`, `m_tkeep` and `m_tlast` hold stable.
- Beats per frame = ceil(`cmd_len`/8). The `rem` subtraction never underflows, because the last-beat branch is taken whenever `rem <= 8`.
- `busy = (state == XFER) || m_tvalid`.
- `frame_done` = `m_tvalid && m_tready && m_tlast`, registered so it pulses in the cycle after that handshake.
- A new command may be accepted while the previous frame's last beat is still held in the output stage.
- Upstream words outside XFER are never consumed (`din_ready = 0` in IDLE).

## Timing
- Reset values: state IDLE, `rem` 0, `m_tvalid` 0, `m_tdata` 0, `m_tkeep` 0, `m_tlast` 0, `frame_done` 0, `err_zero_len` 0. Derived outputs then read `cmd_ready` 1, `din_ready` 0, `busy` 0.
- Command accepted in cycle N → XFER in N+1 → `din_ready` may assert in N+1 → first beat on `m_tvalid` in N+2 at earliest.
- Latency from upstream pull to output beat: 1 cycle. Sustained throughput with `m_tready` held high: 1 beat per cycle.
- Back-to-back frames:
  - Last upstream pull in cycle K → IDLE in K+1.
  - Next command accepted in K+1 → next pull in K+2.
  - This leaves one idle upstream cycle between frames.
- `err_zero_len` pulses in the cycle after the zero-length command handshake.
- Reset asserted mid-frame clears everything immediately (asynchronous). The partial frame is abandoned with no `m_tlast`, and upstream words not yet pulled remain upstream.

## Test plan
- `cmd_len` = 8, `m_tready` = 1 → one beat, `m_tkeep` = 8'hFF, `m_tlast` = 1, `frame_done` pulses once.
- `cmd_len` = 13 → two beats with `m_tkeep` 8'hFF then 8'h1F, `m_tlast` only on the second beat, data words in order.
- `cmd_len` = 1, then immediately `cmd_len` = 0 → one beat with keep 8'h01 and `m_tlast` = 1; `err_zero_len` pulses once; no further beats; `busy` returns to 0.
- `cmd_len` = 64 with random `m_tready` and `din_valid` throttling → exactly 8 beats, data order preserved, outputs stable during stalls, no word lost or duplicated, `din_ready` never high in IDLE.
- Two commands back-to-back (20 bytes, then 9 bytes) with `m_tready` = 1 →
  - First frame: keeps FF, FF, 0F.
  - Second frame: keeps FF, 01.
  - Second command accepted the cycle after the first frame's last pull.
  - Two `frame_done` pulses.
- `rst_n` asserted after 3 beats of a 64-byte frame → all outputs at reset values immediately; after release, `cmd_ready` = 1 and a new 8-byte frame completes normally.
